obuf_writeback: RTL and testbench
=================================

Name: obuf_writeback

Overview:
- Output-side stage directly upstream of the global buffer.
- Accepts accumulated partial sums from the PE array one element per cycle and requantizes each to dataSize bits.
- Packs interfaceDepth elements into one interface word and buffers finished words in a small FIFO.
- Drains the FIFO into the global buffer by issuing I_LOAD_OUTPUT with the word on the write-data path, one word per instruction.

Parameters:
- dataSize, 8, width of one quantized output element (signed).
- accWidth, 24, width of an incoming partial sum (signed).
- interfaceDepth, 16, elements per interface word; interfaceWidth = interfaceDepth*dataSize.
- fifoDepth, 4, packed words buffered; power of two, ≥2.
- shiftWidth, 5, width of the requantization shift amount.

Ports:
- clk  in  1  clock.
- nrst  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous flush of all state; wins over every other event.
- shift_i  in  shiftWidth  arithmetic right-shift amount; must be held stable while busy_o=1.
- psum_valid_i  in  1  psum_data_i valid.
- psum_ready_o  out  1  stage can accept an element.
- psum_data_i  in  accWidth  signed partial sum.
- psum_last_i  in  1  last element of the tile; qualified by valid&ready.
- glb_inst_o  out  global_buffer_instruction_t  I_LOAD_OUTPUT or I_NOP.
- glb_ready_i  in  1  global buffer ready_o.
- glb_wr_data_o  out  interfaceWidth  packed word; valid when glb_inst_o=I_LOAD_OUTPUT.
- words_written_o  out  16  count of I_LOAD_OUTPUT issued since reset/clear; wraps at 65535→0.
- busy_o  out  1  partial word pending or FIFO non-empty.

Behaviour:
- Reset values:
  - Lane index 0, pack register 0, FIFO empty, counter 0.
  - psum_ready_o=1, glb_inst_o=I_NOP, glb_wr_data_o=0, busy_o=0.
- Accept: an element is accepted when psum_valid_i & psum_ready_o. psum_ready_o = !fifo_full, registered state only; it has no combinational path from glb_ready_i or psum_valid_i.
- Requant:
  - shift_i=0: value = psum_data_i.
  - shift_i>0: value = (psum_data_i + 2^(shift_i-1)) >>> shift_i, computed in accWidth+1 bits (round half up).
  - The result saturates to [-2^(dataSize-1), 2^(dataSize-1)-1], i.e. [-128, 127] at default.
- Packing: the accepted element goes to bits [lane*dataSize +: dataSize]; lane increments by 1.
- Word completion: on acceptance with lane==interfaceDepth-1, or with psum_last_i=1:
  - The word (unwritten lanes forced to 0) is pushed into the FIFO in the same edge.
  - Lane resets to 0 and the pack register clears.
  - psum_last_i on lane interfaceDepth-1 produces exactly one word, not an extra empty one.
- Latency: an element completing a word at edge N is in the FIFO after N and can be issued in cycle N+1.
- Drain:
  - In any cycle with FIFO non-empty and glb_ready_i=1: glb_inst_o=I_LOAD_OUTPUT and glb_wr_data_o=FIFO head (combinational).
  - The head pops at the next edge and words_written_o increments.
  - Otherwise glb_inst_o=I_NOP and glb_wr_data_o=0.
- Push and pop in the same cycle are legal; occupancy is unchanged.
- When full, psum_ready_o=0 for that cycle even if a pop occurs; no lookahead.
- Ordering: words leave in completion order; elements within a word are in arrival order.
- FIFO pointers are log2(fifoDepth) bits plus a wrap bit; full and empty are distinguished by the wrap bit.
- clear_i=1:
  - Next edge: lane=0, pack register=0, FIFO empty, counter=0.
  - Any element offered that cycle is dropped; glb_inst_o is still driven that cycle per the drain rule.
- Reset asserted mid-operation discards all pending data immediately (asynchronous).
- busy_o = (lane!=0) | !fifo_empty.

Test Plan:
- Stream 16 psums 0..15 with shift_i=0, glb_ready_i=1 → one I_LOAD_OUTPUT the cycle after the 16th accept, word bytes 0x00..0x0F with lane0 in the LSB; words_written_o=1; busy_o returns to 0.
- shift_i=4; psums 24, -24, 40000, -40000, each with psum_last_i=1 → four words with lane0 = 0x02, 0xFF (-1), 0x7F, 0x80 respectively; upper lanes 0.
- 5 psums with psum_last_i on the 5th → one word with lanes 0-4 filled and lanes 5-15 = 0; a following 16-element tile forms a fresh full word.
- glb_ready_i=0, stream 80 psums → psum_ready_o drops after 4 words (64 accepts) and stays 0; raise glb_ready_i → words issue on consecutive cycles in order, no loss or duplication, final count 5.
- Fill 2 words, then pulse clear_i with psum_valid_i=1 → element dropped, FIFO empty, words_written_o=0, busy_o=0 next cycle.
- Assert nrst low mid-tile with FIFO holding 3 words → all outputs at reset values immediately; no I_LOAD_OUTPUT after release until a new word completes.

Source files
------------

// File: rtl/obuf_writeback.sv
// Output write-back stage: requantizes PE partial sums, packs them into interface
// words, buffers finished words and drains them into the global buffer.
package obuf_writeback_pkg;
    typedef enum logic [1:0] {
        I_NOP         = 2'd0,
        I_LOAD_OUTPUT = 2'd1
    } global_buffer_instruction_t;
endpackage

module obuf_writeback
    import obuf_writeback_pkg::*;
#(
    parameter int unsigned dataSize       = 8,
    parameter int unsigned accWidth       = 24,
    parameter int unsigned interfaceDepth = 16,
    parameter int unsigned fifoDepth      = 4,
    parameter int unsigned shiftWidth     = 5
) (
    input  logic                                clk,
    input  logic                                nrst,
    input  logic                                clear_i,
    input  logic [shiftWidth-1:0]               shift_i,
    input  logic                                psum_valid_i,
    output logic                                psum_ready_o,
    input  logic [accWidth-1:0]                 psum_data_i,
    input  logic                                psum_last_i,
    output global_buffer_instruction_t          glb_inst_o,
    input  logic                                glb_ready_i,
    output logic [interfaceDepth*dataSize-1:0]  glb_wr_data_o,
    output logic [15:0]                         words_written_o,
    output logic                                busy_o
);
    localparam int unsigned IW     = interfaceDepth * dataSize;
    localparam int unsigned LANE_W = $clog2(interfaceDepth);
    localparam int unsigned AW     = $clog2(fifoDepth);
    localparam int unsigned PW     = AW + 1;
    localparam int unsigned SW     = accWidth + 1;

    localparam logic signed [SW-1:0] SAT_MAX = SW'(2 ** (dataSize - 1) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = SW'(-(2 ** (dataSize - 1)));

    logic [LANE_W-1:0]  lane_q;
    logic [IW-1:0]      pack_q;
    logic [IW-1:0]      fifo_mem [fifoDepth];
    logic [PW-1:0]      wr_ptr_q;
    logic [PW-1:0]      rd_ptr_q;
    logic [15:0]        count_q;

    logic               fifo_empty;
    logic               fifo_full;
    logic               accept;
    logic               complete;
    logic               pop;
    logic [SW-1:0]      rnd;
    logic signed [SW-1:0] ext;
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] shifted;
    logic [dataSize-1:0] qelem;
    logic [IW-1:0]      word_c;

    // Pointers carry a wrap bit so equal indices mean empty or full depending on it.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign accept   = psum_valid_i & ~fifo_full;
    assign complete = accept & (psum_last_i | (lane_q == LANE_W'(interfaceDepth - 1)));
    assign pop      = ~fifo_empty & glb_ready_i;

    // Round-half-up arithmetic shift followed by saturation to the element range.
    always_comb begin
        rnd     = '0;
        ext     = {psum_data_i[accWidth-1], psum_data_i};
        if (shift_i != '0) begin
            rnd = SW'(1) << (shift_i - shiftWidth'(1));
        end
        sum     = ext + rnd;
        shifted = sum >>> shift_i;
        qelem   = shifted[dataSize-1:0];
        if (shifted > SAT_MAX) begin
            qelem = SAT_MAX[dataSize-1:0];
        end else if (shifted < SAT_MIN) begin
            qelem = SAT_MIN[dataSize-1:0];
        end
    end

    always_comb begin
        word_c = pack_q;
        word_c[int'(lane_q) * dataSize +: dataSize] = qelem;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            lane_q   <= '0;
            pack_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            lane_q   <= '0;
            pack_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) begin
                if (complete) begin
                    lane_q   <= '0;
                    pack_q   <= '0;
                    wr_ptr_q <= wr_ptr_q + PW'(1);
                end else begin
                    lane_q <= lane_q + LANE_W'(1);
                    pack_q <= word_c;
                end
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
                count_q  <= count_q + 16'd1;
            end
        end
    end

    // Storage needs no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (complete && !clear_i) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= word_c;
        end
    end

    assign psum_ready_o    = ~fifo_full;
    assign glb_inst_o      = pop ? I_LOAD_OUTPUT : I_NOP;
    assign glb_wr_data_o   = pop ? fifo_mem[rd_ptr_q[AW-1:0]] : '0;
    assign words_written_o = count_q;
    assign busy_o          = (lane_q != '0) | ~fifo_empty;

endmodule

// File: tb/tb_obuf_writeback.sv
// Randomized and directed bench for obuf_writeback against a queue-based reference model.
module tb_obuf_writeback;
    import obuf_writeback_pkg::*;

    logic                        clk = 1'b0;
    logic                        nrst = 1'b0;
    logic                        clear_i = 1'b0;
    logic [4:0]                  shift_i = '0;
    logic                        psum_valid_i = 1'b0;
    logic                        psum_ready_o;
    logic [23:0]                 psum_data_i = '0;
    logic                        psum_last_i = 1'b0;
    global_buffer_instruction_t  glb_inst_o;
    logic                        glb_ready_i = 1'b0;
    logic [127:0]                glb_wr_data_o;
    logic [15:0]                 words_written_o;
    logic                        busy_o;

    obuf_writeback dut (
        .clk             (clk),
        .nrst            (nrst),
        .clear_i         (clear_i),
        .shift_i         (shift_i),
        .psum_valid_i    (psum_valid_i),
        .psum_ready_o    (psum_ready_o),
        .psum_data_i     (psum_data_i),
        .psum_last_i     (psum_last_i),
        .glb_inst_o      (glb_inst_o),
        .glb_ready_i     (glb_ready_i),
        .glb_wr_data_o   (glb_wr_data_o),
        .words_written_o (words_written_o),
        .busy_o          (busy_o)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model state
    logic [127:0]        mq[$];
    longint              elems[$];
    int unsigned         mcount = 0;

    // Driver state
    logic signed [23:0]  pend_d[$];
    bit                  pend_l[$];
    logic [127:0]        issued[$];
    int unsigned         g_vprob = 100;
    int unsigned         g_rprob = 100;
    bit                  g_clear = 1'b0;
    int unsigned         g_shift = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint requant(input logic signed [23:0] p, input int unsigned s);
        longint v;
        v = longint'(p);
        if (s > 0) v = (v + (longint'(1) << (s - 1))) >>> s;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return v;
    endfunction

    function automatic logic [127:0] make_word();
        logic [127:0] w;
        w = '0;
        foreach (elems[i]) w[i*8 +: 8] = 8'(elems[i]);
        return w;
    endfunction

    task automatic model_reset();
        mq.delete();
        elems.delete();
        mcount = 0;
    endtask

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic step();
        bit v, full, pop, acc;
        v = (pend_d.size() > 0) && ($urandom_range(99) < g_vprob);
        psum_valid_i = v;
        psum_data_i  = v ? pend_d[0] : 24'h0;
        psum_last_i  = v ? pend_l[0] : 1'b0;
        glb_ready_i  = ($urandom_range(99) < g_rprob);
        clear_i      = g_clear;
        shift_i      = 5'(g_shift);
        #1;
        full = (mq.size() == 4);
        pop  = (mq.size() > 0) && glb_ready_i;
        check_eq("ready", 128'(psum_ready_o), 128'(!full));
        check_eq("inst", 128'(glb_inst_o == I_LOAD_OUTPUT), 128'(pop));
        check_eq("wdata", glb_wr_data_o, pop ? mq[0] : 128'h0);
        check_eq("busy", 128'(busy_o), 128'((elems.size() > 0) || (mq.size() > 0)));
        check_eq("count", 128'(words_written_o), 128'(mcount));
        if (glb_inst_o == I_LOAD_OUTPUT) issued.push_back(glb_wr_data_o);
        if (g_clear) begin
            model_reset();
        end else begin
            acc = v && !full;
            if (pop) begin
                void'(mq.pop_front());
                mcount = (mcount + 1) % 65536;
            end
            if (acc) begin
                elems.push_back(requant(pend_d[0], g_shift));
                if (elems.size() == 16 || pend_l[0]) begin
                    mq.push_back(make_word());
                    elems.delete();
                end
                void'(pend_d.pop_front());
                void'(pend_l.pop_front());
            end
        end
        @(negedge clk);
    endtask

    task automatic run_idle(input int unsigned bound);
        int unsigned n;
        n = 0;
        while ((pend_d.size() > 0 || mq.size() > 0 || elems.size() > 0) && n < bound) begin
            step();
            n++;
        end
        if (n >= bound) check_eq("timeout", 128'd0, 128'd1);
    endtask

    task automatic push(input logic signed [23:0] d, input bit l);
        pend_d.push_back(d);
        pend_l.push_back(l);
    endtask

    task automatic do_clear();
        g_clear = 1'b1;
        step();
        g_clear = 1'b0;
        issued.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, 128'(psum_ready_o), 128'd1);
        check_eq({tag, "_inst"}, 128'(glb_inst_o == I_NOP), 128'd1);
        check_eq({tag, "_wdata"}, glb_wr_data_o, 128'h0);
        check_eq({tag, "_busy"}, 128'(busy_o), 128'd0);
        check_eq({tag, "_count"}, 128'(words_written_o), 128'd0);
    endtask

    initial begin
        logic [127:0] w;
        int unsigned n;
        #1;
        glb_ready_i = 1'b1;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        nrst = 1'b1;

        // Full 16-element tile, no shift
        do_clear();
        g_shift = 0; g_rprob = 100; g_vprob = 100;
        for (int i = 0; i < 16; i++) push(24'(i), 1'b0);
        run_idle(200);
        check_eq("t1_nwords", 128'(issued.size()), 128'd1);
        if (issued.size() > 0)
            check_eq("t1_word", issued[0], 128'h0F0E0D0C0B0A09080706050403020100);
        check_eq("t1_count", 128'(words_written_o), 128'd1);
        check_eq("t1_busy", 128'(busy_o), 128'd0);

        // Rounding and saturation, single-element tiles
        do_clear();
        g_shift = 4;
        push(24'sd24, 1'b1); push(-24'sd24, 1'b1); push(24'sd40000, 1'b1); push(-24'sd40000, 1'b1);
        run_idle(200);
        check_eq("t2_nwords", 128'(issued.size()), 128'd4);
        if (issued.size() == 4) begin
            check_eq("t2_w0", issued[0], 128'h02);
            check_eq("t2_w1", issued[1], 128'hFF);
            check_eq("t2_w2", issued[2], 128'h7F);
            check_eq("t2_w3", issued[3], 128'h80);
        end

        // Short tile then a fresh full tile
        do_clear();
        g_shift = 0;
        for (int i = 1; i <= 5; i++) push(24'(i), i == 5);
        for (int i = 16; i < 32; i++) push(24'(i), 1'b0);
        run_idle(200);
        check_eq("t3_nwords", 128'(issued.size()), 128'd2);
        if (issued.size() == 2) begin
            check_eq("t3_w0", issued[0], 128'h0504030201);
            check_eq("t3_w1", issued[1], 128'h1F1E1D1C1B1A19181716151413121110);
        end

        // Backpressure: FIFO fills, then drains in order
        do_clear();
        g_rprob = 0;
        for (int i = 0; i < 80; i++) push(24'(i & 8'h7f), 1'b0);
        repeat (90) step();
        check_eq("t4_ready_low", 128'(psum_ready_o), 128'd0);
        check_eq("t4_pending", 128'(pend_d.size()), 128'd16);
        g_rprob = 100;
        run_idle(300);
        check_eq("t4_nwords", 128'(issued.size()), 128'd5);
        check_eq("t4_count", 128'(words_written_o), 128'd5);
        if (issued.size() == 5) begin
            for (int k = 0; k < 5; k++) begin
                w = '0;
                for (int j = 0; j < 16; j++) w[j*8 +: 8] = 8'((16*k + j) & 8'h7f);
                check_eq("t4_order", issued[k], w);
            end
        end

        // Clear drops the offered element and flushes the FIFO
        do_clear();
        g_rprob = 0;
        for (int i = 0; i < 32; i++) push(24'(i), 1'b0);
        n = 0;
        while (pend_d.size() > 0 && n < 100) begin step(); n++; end
        check_eq("t5_fill", 128'(mq.size()), 128'd2);
        push(24'sd99, 1'b1);
        g_clear = 1'b1;
        step();
        g_clear = 1'b0;
        pend_d.delete(); pend_l.delete();
        #1;
        check_eq("t5_busy", 128'(busy_o), 128'd0);
        check_eq("t5_count", 128'(words_written_o), 128'd0);
        check_eq("t5_ready", 128'(psum_ready_o), 128'd1);
        @(negedge clk);
        g_rprob = 100;
        repeat (4) step();

        // Asynchronous reset mid-tile with three words buffered
        do_clear();
        g_rprob = 0;
        for (int i = 0; i < 56; i++) push(24'(i), 1'b0);
        n = 0;
        while (pend_d.size() > 0 && n < 100) begin step(); n++; end
        psum_valid_i = 1'b0;
        glb_ready_i  = 1'b1;
        #2;
        nrst = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        model_reset();
        @(negedge clk);
        nrst = 1'b1;
        g_rprob = 100;
        issued.delete();
        repeat (8) step();
        check_eq("t6_quiet", 128'(issued.size()), 128'd0);
        for (int i = 0; i < 16; i++) push(24'(i + 3), 1'b0);
        run_idle(200);
        check_eq("t6_after", 128'(issued.size()), 128'd1);

        // Random traffic
        do_clear();
        g_vprob = 80; g_rprob = 70;
        for (int c = 0; c < 3000; c++) begin
            if (pend_d.size() == 0) begin
                int unsigned len;
                if (mq.size() == 0 && elems.size() == 0) g_shift = $urandom_range(8);
                len = $urandom_range(20, 1);
                for (int i = 0; i < int'(len); i++) begin
                    logic signed [23:0] d;
                    d = ($urandom_range(1) == 0) ? 24'($urandom) : 24'($signed(10'($urandom)));
                    push(d, (i == int'(len) - 1) || ($urandom_range(15) == 0));
                end
            end
            step();
        end
        g_vprob = 100; g_rprob = 100;
        run_idle(1000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
